// File: rtl/cpa_share_ctrl.sv
// ---------------------------------------------------------------------------
// cpa_share_ctrl
//
// Time-shares one external, purely combinational WIDTH-bit ripple adder
// among NUM_REQ requesters. Arbitration is round-robin. The winner's operands
// are latched and held on the adder inputs for SETTLE_CYCLES cycles. The sum
// is then captured and returned, tagged with the requester index, on a single
// valid/ready response channel.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  per-requester request valid                  [NUM_REQ]
//   req_ready  per-requester accept, at most one bit high   [NUM_REQ]
//   req_a      packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand B, same packing as req_a
//   add_in1    adder operand 1 (the latched A)
//   add_in2    adder operand 2 (the latched B)
//   add_sum    adder result
//   rsp_valid  response valid
//   rsp_ready  response accept
//   rsp_id     index of the requester that owns the response
//   rsp_sum    registered sum, (A+B) mod 2^WIDTH
//   busy       high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module cpa_share_ctrl #(
  parameter int WIDTH         = 11,
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,   // must equal clog2(NUM_REQ)
  parameter int SETTLE_CYCLES = 1    // 1..15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_in1,
  output logic [WIDTH-1:0]         add_in2,
  input  logic [WIDTH-1:0]         add_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     busy
);

  // Wide enough for SETTLE_CYCLES-1 up to 14.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q,      state_d;
  logic [ID_W-1:0]    rr_ptr_q,     rr_ptr_d;
  logic [WIDTH-1:0]   op_a_q,       op_a_d;
  logic [WIDTH-1:0]   op_b_q,       op_b_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0]   rsp_sum_q,    rsp_sum_d;
  logic [ID_W-1:0]    rsp_id_q,     rsp_id_d;

  // -------------------------------------------------------------------------
  // Round-robin arbiter: first valid requester at or after rr_ptr, wrapping.
  // -------------------------------------------------------------------------
  logic            found;
  logic [ID_W-1:0] win;
  logic            grant;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int              idx_int;
      logic [ID_W-1:0] idx;
      idx_int = (int'(rr_ptr_q) + k) % NUM_REQ;
      idx     = ID_W'(idx_int);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Accept only in IDLE, and never while reset is asserted, so the ready
  // outputs are quiet during reset even though the flops are already cleared.
  assign grant = (state_q == IDLE) && found && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath updates
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    settle_cnt_d = settle_cnt_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          op_a_d       = req_a[int'(win)*WIDTH +: WIDTH];
          op_b_d       = req_b[int'(win)*WIDTH +: WIDTH];
          rsp_id_d     = win;
          rr_ptr_d     = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          settle_cnt_d = CNT_W'(SETTLE_CYCLES - 1);
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        // The counter reaching zero marks the last settle cycle; the ripple
        // adder has had the full window by the end of it.
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end else begin
          rsp_sum_d = add_sum;
          state_d   = RESP;
        end
      end

      RESP: begin
        // Return to IDLE only; arbitration reopens on the following cycle.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments only in clocked blocks, so every flop
    // samples its _d value from before the edge regardless of statement order.
    // The operand and result registers are reset too: the adder inputs are
    // driven straight from op_a/op_b and must read zero out of reset.
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      settle_cnt_q <= '0;
      rsp_sum_q    <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      settle_cnt_q <= settle_cnt_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign add_in1   = op_a_q;
  assign add_in2   = op_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cpa_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpa_share_ctrl
//
// Two instances share clk/rst: d1 uses SETTLE_CYCLES=1 with a behavioural
// adder (sum of its own adder outputs); d4 uses SETTLE_CYCLES=4 with an adder
// output the bench can override to expose when the sum is sampled.
// ---------------------------------------------------------------------------
module tb_cpa_share_ctrl;

  localparam int W  = 11;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // d1 : SETTLE_CYCLES = 1
  logic [N-1:0]   d1_req_valid, d1_req_ready;
  logic [N*W-1:0] d1_req_a, d1_req_b;
  logic [W-1:0]   d1_add_in1, d1_add_in2, d1_add_sum;
  logic           d1_rsp_valid, d1_rsp_ready, d1_busy;
  logic [IW-1:0]  d1_rsp_id;
  logic [W-1:0]   d1_rsp_sum;

  // d4 : SETTLE_CYCLES = 4
  logic [N-1:0]   d4_req_valid, d4_req_ready;
  logic [N*W-1:0] d4_req_a, d4_req_b;
  logic [W-1:0]   d4_add_in1, d4_add_in2, d4_add_sum, d4_add_force;
  logic           d4_add_model;
  logic           d4_rsp_valid, d4_rsp_ready, d4_busy;
  logic [IW-1:0]  d4_rsp_id;
  logic [W-1:0]   d4_rsp_sum;

  assign d1_add_sum = d1_add_in1 + d1_add_in2;
  assign d4_add_sum = d4_add_model ? W'(d4_add_in1 + d4_add_in2) : d4_add_force;

  cpa_share_ctrl #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW), .SETTLE_CYCLES(1)) u_d1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (d1_req_valid),
    .req_ready (d1_req_ready),
    .req_a     (d1_req_a),
    .req_b     (d1_req_b),
    .add_in1   (d1_add_in1),
    .add_in2   (d1_add_in2),
    .add_sum   (d1_add_sum),
    .rsp_valid (d1_rsp_valid),
    .rsp_ready (d1_rsp_ready),
    .rsp_id    (d1_rsp_id),
    .rsp_sum   (d1_rsp_sum),
    .busy      (d1_busy)
  );

  cpa_share_ctrl #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW), .SETTLE_CYCLES(4)) u_d4 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (d4_req_valid),
    .req_ready (d4_req_ready),
    .req_a     (d4_req_a),
    .req_b     (d4_req_b),
    .add_in1   (d4_add_in1),
    .add_in2   (d4_add_in2),
    .add_sum   (d4_add_sum),
    .rsp_valid (d4_rsp_valid),
    .rsp_ready (d4_rsp_ready),
    .rsp_id    (d4_rsp_id),
    .rsp_sum   (d4_rsp_sum),
    .busy      (d4_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One d1 transaction with rsp_ready held high. Entered about 1 time unit
  // after a clock edge with d1 in IDLE and the request inputs applied.
  task automatic run1(input string tag, input int w,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_sum);
    int n;
    #1;
    check({tag, " ready"}, 32'(d1_req_ready), 32'(1) << w);
    check({tag, " idle busy"}, 32'(d1_busy), 0);
    @(posedge clk); #1;                      // handshake edge
    n = 0;
    while (!d1_rsp_valid && n < 20) begin
      check({tag, " settle busy"}, 32'(d1_busy), 1);
      check({tag, " settle in1"}, 32'(d1_add_in1), 32'(a));
      check({tag, " settle in2"}, 32'(d1_add_in2), 32'(b));
      check({tag, " settle ready"}, 32'(d1_req_ready), 0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 1);
    check({tag, " sum"}, 32'(d1_rsp_sum), 32'(exp_sum));
    check({tag, " id"}, 32'(d1_rsp_id), w);
    check({tag, " resp busy"}, 32'(d1_busy), 1);
    @(posedge clk); #1;                      // response accepted
    check({tag, " done valid"}, 32'(d1_rsp_valid), 0);
    check({tag, " done busy"}, 32'(d1_busy), 0);
  endtask

  typedef struct {
    int         req;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{0, 11'h005, 11'h00A, 11'h00F};
    vecs[1] = '{0, 11'h7FF, 11'h001, 11'h000};
    vecs[2] = '{0, 11'h400, 11'h400, 11'h000};
    vecs[3] = '{0, 11'h3FF, 11'h3FF, 11'h7FE};
    vecs[4] = '{1, 11'h123, 11'h456, 11'h579};
    vecs[5] = '{2, 11'h7FF, 11'h7FF, 11'h7FE};
    vecs[6] = '{3, 11'h000, 11'h000, 11'h000};
    vecs[7] = '{3, 11'h2AA, 11'h155, 11'h3FF};

    rst          = 1'b1;
    d1_req_valid = '1;
    d1_req_a     = '0;
    d1_req_b     = '0;
    d1_rsp_ready = 1'b1;
    d4_req_valid = '0;
    d4_req_a     = '0;
    d4_req_b     = '0;
    d4_rsp_ready = 1'b1;
    d4_add_model = 1'b1;
    d4_add_force = '0;

    // ---- reset state ----
    #3;
    check("reset ready", 32'(d1_req_ready), 0);
    check("reset busy", 32'(d1_busy), 0);
    check("reset valid", 32'(d1_rsp_valid), 0);
    check("reset in1", 32'(d1_add_in1), 0);
    check("reset in2", 32'(d1_add_in2), 0);
    check("reset sum", 32'(d1_rsp_sum), 0);
    d1_req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- single requests, incl. wrap-around ----
    for (int i = 0; i < 8; i++) begin
      d1_req_valid                   = 4'b0001 << vecs[i].req;
      d1_req_a[vecs[i].req*W +: W]   = vecs[i].a;
      d1_req_b[vecs[i].req*W +: W]   = vecs[i].b;
      run1($sformatf("vec%0d", i), vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].sum);
    end
    d1_req_valid = '0;

    // ---- backpressure (rr_ptr is 0 after the last grant to 3) ----
    d1_req_valid     = 4'b0100;
    d1_req_a[2*W +: W] = 11'h100;
    d1_req_b[2*W +: W] = 11'h011;
    d1_rsp_ready     = 1'b0;
    #1;
    check("bp ready", 32'(d1_req_ready), 32'b0100);
    @(posedge clk); #1;
    d1_req_valid = 4'b1111;
    #1;
    check("bp settle ready", 32'(d1_req_ready), 0);
    @(posedge clk); #1;
    check("bp valid", 32'(d1_rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold valid", 32'(d1_rsp_valid), 1);
      check("bp hold id", 32'(d1_rsp_id), 2);
      check("bp hold sum", 32'(d1_rsp_sum), 32'h111);
      check("bp hold in1", 32'(d1_add_in1), 32'h100);
      check("bp hold in2", 32'(d1_add_in2), 32'h011);
      check("bp hold ready", 32'(d1_req_ready), 0);
    end
    d1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp done valid", 32'(d1_rsp_valid), 0);
    check("bp next winner", 32'(d1_req_ready), 32'b1000);
    d1_req_valid = '0;
    #1;
    check("bp drop ready", 32'(d1_req_ready), 0);

    // ---- round-robin from reset ----
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d1_req_a     = {11'h404, 11'h303, 11'h202, 11'h101};
    d1_req_b     = {11'h700, 11'h033, 11'h022, 11'h011};
    d1_req_valid = 4'b1111;
    run1("rr0", 0, 11'h101, 11'h011, 11'h112);
    run1("rr1", 1, 11'h202, 11'h022, 11'h224);
    run1("rr2", 2, 11'h303, 11'h033, 11'h336);
    run1("rr3", 3, 11'h404, 11'h700, 11'h304);
    run1("rr4", 0, 11'h101, 11'h011, 11'h112);
    d1_req_valid = '0;

    // ---- SETTLE_CYCLES=4: latency and sample point ----
    d4_req_valid       = 4'b0010;
    d4_req_a[1*W +: W] = 11'h0F0;
    d4_req_b[1*W +: W] = 11'h00F;
    d4_add_model       = 1'b0;
    d4_add_force       = 11'h555;
    d4_rsp_ready       = 1'b0;
    #1;
    check("s4 ready", 32'(d4_req_ready), 32'b0010);
    @(posedge clk); #1;                      // handshake edge
    d4_req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      check("s4 settle valid", 32'(d4_rsp_valid), 0);
      check("s4 settle busy", 32'(d4_busy), 1);
      check("s4 settle in1", 32'(d4_add_in1), 32'h0F0);
      check("s4 settle in2", 32'(d4_add_in2), 32'h00F);
      // Only the last settle cycle presents the right sum.
      d4_add_force = (i == 3) ? 11'h0FF : (11'h555 ^ W'(i));
      @(posedge clk); #1;
    end
    check("s4 valid", 32'(d4_rsp_valid), 1);
    check("s4 sum", 32'(d4_rsp_sum), 32'h0FF);
    check("s4 id", 32'(d4_rsp_id), 1);
    d4_add_force = 11'h7AA;
    @(posedge clk); #1;
    check("s4 hold sum", 32'(d4_rsp_sum), 32'h0FF);
    d4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("s4 done busy", 32'(d4_busy), 0);

    // ---- reset mid-SETTLE (rr_ptr is 2 here) ----
    d4_add_model       = 1'b1;
    d4_req_a[0*W +: W] = 11'h321;
    d4_req_b[0*W +: W] = 11'h123;
    d4_req_a[2*W +: W] = 11'h600;
    d4_req_b[2*W +: W] = 11'h300;
    d4_req_valid       = 4'b0101;
    #1;
    check("rst pre ready", 32'(d4_req_ready), 32'b0100);
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("rst pre busy", 32'(d4_busy), 1);
    rst = 1'b1;
    #1;
    check("rst busy", 32'(d4_busy), 0);
    check("rst valid", 32'(d4_rsp_valid), 0);
    check("rst in1", 32'(d4_add_in1), 0);
    check("rst in2", 32'(d4_add_in2), 0);
    check("rst ready", 32'(d4_req_ready), 0);
    check("rst sum", 32'(d4_rsp_sum), 0);
    check("rst id", 32'(d4_rsp_id), 0);
    @(posedge clk); #1;
    check("rst held valid", 32'(d4_rsp_valid), 0);
    rst = 1'b0;
    #1;
    check("post rst ready", 32'(d4_req_ready), 32'b0001);
    check("post rst valid", 32'(d4_rsp_valid), 0);
    @(posedge clk); #1;                      // handshake edge
    d4_req_valid = '0;
    n = 0;
    while (!d4_rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("post rst latency", n, 4);
    check("post rst sum", 32'(d4_rsp_sum), 32'h444);
    check("post rst id", 32'(d4_rsp_id), 0);
    @(posedge clk); #1;
    check("post rst done", 32'(d4_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
